pwm_mode_ctrl: RTL

Configuration controller for the board's PWM generator. It debounces the two push keys, selects the 50 Hz or 60 Hz output mode, and computes the matching period and high-time. It delivers each new configuration to the PWM core over a valid/ready handshake, and the core accepts it only at its own period boundary. The mode LEDs show the configuration the core has actually accepted.

---
 rtl/pwm_mode_ctrl_if.sv | 10 +
 rtl/pwm_mode_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pwm_mode_ctrl_if.sv
// rtl/pwm_mode_ctrl_if.sv - configuration handshake between the mode controller and the PWM core
interface pwm_mode_ctrl_if;
  logic [31:0] cfg_period;
  logic [31:0] cfg_high;
  logic        cfg_valid;
  logic        cfg_ready;

  modport master (output cfg_period, output cfg_high, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_period, input cfg_high, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/pwm_mode_ctrl.sv
// rtl/pwm_mode_ctrl.sv - key debounce, 50/60 Hz mode select and PWM config offer
module pwm_mode_ctrl #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DUTY_PCT        = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key0,
  input  logic                  key1,
  pwm_mode_ctrl_if.master       cfg,
  output logic                  led0,
  output logic                  led1,
  output logic                  busy
);

  localparam longint unsigned P0L = 64'(CLK_HZ) / 64'd50;
  localparam longint unsigned P1L = 64'(CLK_HZ) / 64'd60;
  localparam longint unsigned H0L = (P0L * 64'(DUTY_PCT)) / 64'd100;
  localparam longint unsigned H1L = (P1L * 64'(DUTY_PCT)) / 64'd100;
  localparam logic [31:0] P0 = 32'(P0L);
  localparam logic [31:0] P1 = 32'(P1L);
  localparam logic [31:0] H0 = 32'(H0L);
  localparam logic [31:0] H1 = 32'(H1L);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         pressed;
  logic [1:0]         pressed_prev_q, pressed_prev_d;
  logic [1:0]         key_ev;
  logic               req_mode_q, req_mode_d;
  logic               offer_mode_q, offer_mode_d;
  logic               applied_mode_q, applied_mode_d;
  logic               applied_vld_q, applied_vld_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic [31:0]        cfg_period_q, cfg_period_d;
  logic [31:0]        cfg_high_q, cfg_high_d;

  // Synchronize both keys, then count consecutive low samples per key.
  always_comb begin
    sync1_d        = {key1, key0};
    sync2_d        = sync1_q;
    cnt_d          = cnt_q;
    pressed        = '0;
    for (int i = 0; i < 2; i++) begin
      pressed[i] = (cnt_q[i] == DEB_MAX);
      if (sync2_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != DEB_MAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    pressed_prev_d = pressed;
    key_ev         = pressed & ~pressed_prev_q;
    req_mode_d     = req_mode_q;
    if (key_ev == 2'b01) req_mode_d = 1'b0;
    if (key_ev == 2'b10) req_mode_d = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    offer_mode_d   = offer_mode_q;
    applied_mode_d = applied_mode_q;
    applied_vld_d  = applied_vld_q;
    cfg_valid_d    = cfg_valid_q;
    cfg_period_d   = cfg_period_q;
    cfg_high_d     = cfg_high_q;
    case (state_q)
      IDLE: begin
        if ((req_mode_q != applied_mode_q) || !applied_vld_q) begin
          state_d      = OFFER;
          offer_mode_d = req_mode_q;
          cfg_valid_d  = 1'b1;
          cfg_period_d = req_mode_q ? P1 : P0;
          cfg_high_d   = req_mode_q ? H1 : H0;
        end
      end
      OFFER: begin
        // Payload is frozen here; new requests only move req_mode.
        if (cfg_valid_q && cfg.cfg_ready) begin
          state_d        = IDLE;
          cfg_valid_d    = 1'b0;
          applied_mode_d = offer_mode_q;
          applied_vld_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sync1_q        <= 2'b11;
      sync2_q        <= 2'b11;
      cnt_q          <= '0;
      pressed_prev_q <= '0;
      req_mode_q     <= 1'b0;
      offer_mode_q   <= 1'b0;
      applied_mode_q <= 1'b0;
      applied_vld_q  <= 1'b0;
      cfg_valid_q    <= 1'b0;
      cfg_period_q   <= '0;
      cfg_high_q     <= '0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      cnt_q          <= cnt_d;
      pressed_prev_q <= pressed_prev_d;
      req_mode_q     <= req_mode_d;
      offer_mode_q   <= offer_mode_d;
      applied_mode_q <= applied_mode_d;
      applied_vld_q  <= applied_vld_d;
      cfg_valid_q    <= cfg_valid_d;
      cfg_period_q   <= cfg_period_d;
      cfg_high_q     <= cfg_high_d;
    end
  end

  assign cfg.cfg_period = cfg_period_q;
  assign cfg.cfg_high   = cfg_high_q;
  assign cfg.cfg_valid  = cfg_valid_q;
  assign led0           = applied_vld_q & ~applied_mode_q;
  assign led1           = applied_vld_q & applied_mode_q;
  assign busy           = (state_q == OFFER);

endmodule
